bram_stream_reader: RTL and testbench



---
 rtl/bram_stream_reader.sv | 158 +++++++++++++++
 tb/tb_bram_stream_reader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// Read sequencer for a single-port, registered-read block RAM: issues a run of
// sequential reads and re-times the returned words onto a valid/ready stream.
module bram_stream_reader #(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [RAM_ADDR_BITS-1:0] start_addr,
    input  logic [RAM_ADDR_BITS:0]   length,
    output logic                     busy,
    output logic                     done,
    output logic                     ram_enable,
    output logic                     write_enable,
    output logic [RAM_ADDR_BITS-1:0] ram_address,
    input  logic [RAM_WIDTH-1:0]     ram_data,
    output logic [RAM_WIDTH-1:0]     out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last
);
    localparam int                       DEPTH    = 3;
    localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = 1;
    localparam logic [RAM_ADDR_BITS:0]   LEN_ONE  = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t r_state, w_state_next;

    logic [RAM_ADDR_BITS-1:0] r_addr;
    logic [RAM_ADDR_BITS:0]   r_remaining;
    logic                     r_inflight;
    logic                     r_inflight_last;
    logic                     r_done;

    logic [RAM_WIDTH-1:0] r_buf_data [DEPTH];
    logic                 r_buf_last [DEPTH];
    logic [1:0]           r_wr_ptr, r_rd_ptr, r_count;

    logic                 w_issue, w_push, w_pop, w_room, w_head_last;
    logic [RAM_WIDTH-1:0] w_head_data;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Words already buffered plus the one still in the RAM pipeline must leave room.
    assign w_room  = ({1'b0, r_count} + {2'b00, r_inflight}) < 3'd3;
    assign w_push  = r_inflight;
    assign w_pop   = out_valid && out_ready;

    always_comb begin
        w_head_data = r_buf_data[0];
        w_head_last = r_buf_last[0];
        case (r_rd_ptr)
            2'd1: begin
                w_head_data = r_buf_data[1];
                w_head_last = r_buf_last[1];
            end
            2'd2: begin
                w_head_data = r_buf_data[2];
                w_head_last = r_buf_last[2];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && length != '0) w_state_next = RUN;
            end
            RUN: begin
                if (w_room && r_remaining != '0) begin
                    w_issue = 1'b1;
                    if (r_remaining == LEN_ONE) w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_pop && w_head_last) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done          <= 1'b0;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remaining == LEN_ONE);
            if (r_state == IDLE && start) begin
                if (length != '0) begin
                    r_addr      <= start_addr;
                    r_remaining <= length;
                end else begin
                    r_done <= 1'b1;
                end
            end else if (w_issue) begin
                r_addr      <= r_addr + ADDR_ONE;
                r_remaining <= r_remaining - LEN_ONE;
            end
            if (r_state == DRAIN && w_state_next == IDLE) r_done <= 1'b1;
        end
    end

    // Output buffer: the returning RAM word is pushed unconditionally; the issue
    // rule guarantees there is a free slot for it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_data[i] <= '0;
                r_buf_last[i] <= 1'b0;
            end
        end else begin
            if (w_push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_wr_ptr == 2'(i)) begin
                        r_buf_data[i] <= ram_data;
                        r_buf_last[i] <= r_inflight_last;
                    end
                end
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: ;
            endcase
        end
    end

    assign busy         = (r_state != IDLE);
    assign done         = r_done;
    assign ram_enable   = w_issue;
    assign write_enable = 1'b0;
    assign ram_address  = r_addr;
    assign out_valid    = (r_count != 2'd0);
    assign out_data     = out_valid ? w_head_data : '0;
    assign out_last     = out_valid && w_head_last;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: directed scenarios plus randomized transfers
// checked against an address-order stream model over a behavioural RAM.
module tb_bram_stream_reader;
    localparam int W     = 8;
    localparam int AB    = 10;
    localparam int LW    = AB + 1;
    localparam int DEPTH = 1 << AB;

    logic          clock = 1'b0;
    logic          reset, start;
    logic [AB-1:0] start_addr;
    logic [AB:0]   length;
    logic          busy, done, ram_enable, write_enable;
    logic [AB-1:0] ram_address;
    logic [W-1:0]  ram_data, out_data;
    logic          out_valid, out_ready, out_last;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] mem [DEPTH];

    always #5 clock = ~clock;

    // Behavioural single-port RAM with registered read.
    always @(posedge clock) begin
        if (ram_enable && !write_enable) ram_data <= mem[ram_address];
    end

    bram_stream_reader #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .start_addr   (start_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .ram_enable   (ram_enable),
        .write_enable (write_enable),
        .ram_address  (ram_address),
        .ram_data     (ram_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_en"},    32'(ram_enable), 0);
        check({tag, "_we"},    32'(write_enable), 0);
        check({tag, "_addr"},  32'(ram_address), 0);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_last"},  32'(out_last), 0);
        check({tag, "_data"},  32'(out_data), 0);
    endtask

    // mode 0: ready=1 with cycle-exact timing; 1: ready low cycles 2..9;
    // 2: random ready (p1 = percent); 3: stray start at cycle p1; 4: reset at cycle p1.
    task automatic xfer(input string tag, input int addr, input int len, input int mode, input int p1);
        int     issued, popped, budget;
        logic   pv, prdy, plast, rdy;
        logic [W-1:0] pdata;
        bit     finished, exact;
        issued = 0; popped = 0; pv = 0; prdy = 1; plast = 0; pdata = '0;
        finished = 0;
        exact  = (mode == 0) || (mode == 3);
        budget = 8 * len + 60;
        for (int c = 0; c < budget && !finished; c++) begin
            start = (c == 0) || (mode == 3 && c == p1);
            if (c == 0) begin
                start_addr = AB'(addr);
                length     = LW'(len);
            end else if (mode == 3 && c == p1) begin
                start_addr = AB'(100);
                length     = LW'(7);
            end
            reset = (mode == 4 && c == p1);
            case (mode)
                1:       rdy = !(c >= 2 && c <= 9);
                2:       rdy = ($urandom_range(0, 99) < p1);
                default: rdy = 1'b1;
            endcase
            out_ready = rdy;
            #2;
            if (mode == 4 && c == p1 + 1) begin
                check_idle_zero({tag, "_after_reset"});
                start = 0;
                for (int k = 0; k < 6; k++) begin
                    tick();
                    #2;
                    check({tag, "_no_done"}, 32'(done), 0);
                    check({tag, "_no_valid"}, 32'(out_valid), 0);
                end
                finished = 1;
            end else begin
                if (c == 1) check({tag, "_we"}, 32'(write_enable), 0);
                if (ram_enable) begin
                    check({tag, "_addr"}, 32'(ram_address), 32'((addr + issued) % DEPTH));
                    issued++;
                end
                check({tag, "_outstanding"}, 32'((issued - popped) <= 3), 1);
                if (pv && !prdy) begin
                    check({tag, "_hold_valid"}, 32'(out_valid), 1);
                    check({tag, "_hold_data"},  32'(out_data), 32'(pdata));
                    check({tag, "_hold_last"},  32'(out_last), 32'(plast));
                end
                if (exact && !done) begin
                    check({tag, "_t_en"},    32'(ram_enable), 32'(c >= 1 && c <= len));
                    check({tag, "_t_valid"}, 32'(out_valid),  32'(c >= 3 && c <= len + 2));
                    check({tag, "_t_busy"},  32'(busy),       32'(c >= 1 && c <= len + 2));
                end
                if (mode == 1 && c == 9) check({tag, "_stall_issued"}, 32'(issued), 3);
                if (out_valid && out_ready) begin
                    check({tag, "_data"}, 32'(out_data), 32'(mem[(addr + popped) % DEPTH]));
                    check({tag, "_last"}, 32'(out_last), 32'(popped == len - 1));
                    popped++;
                end
                if (done && mode != 4) begin
                    check({tag, "_done_busy"}, 32'(busy), 0);
                    check({tag, "_done_words"}, 32'(popped), 32'(len));
                    check({tag, "_done_issued"}, 32'(issued), 32'(len));
                    if (exact) check({tag, "_done_cycle"}, 32'(c), 32'(len + 3));
                    finished = 1;
                end
            end
            pv = out_valid; prdy = out_ready; pdata = out_data; plast = out_last;
            tick();
        end
        check({tag, "_timeout"}, 32'(finished), 1);
        start = 0;
        reset = 0;
        #2;
        check({tag, "_pulse_end"}, 32'(done), 0);
        check({tag, "_idle_busy"}, 32'(busy), 0);
        check({tag, "_idle_valid"}, 32'(out_valid), 0);
        $display("[TB] transfer %s addr=%0d len=%0d mode=%0d words=%0d", tag, addr, len, mode, popped);
        tick();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = W'(i);
        reset = 1; start = 0; start_addr = '0; length = '0; out_ready = 0;
        repeat (3) tick();
        #2;
        check_idle_zero("reset");
        reset = 0;
        tick();

        xfer("basic", 5, 4, 0, 0);
        xfer("stall", 5, 4, 1, 0);
        xfer("wrap", 1022, 4, 0, 0);

        // Zero-length command: immediate done, nothing else moves.
        start = 1; start_addr = AB'(50); length = '0; out_ready = 1;
        #2;
        check("zero_c0_busy", 32'(busy), 0);
        tick();
        start = 0;
        #2;
        check("zero_done", 32'(done), 1);
        check("zero_busy", 32'(busy), 0);
        check("zero_en", 32'(ram_enable), 0);
        check("zero_valid", 32'(out_valid), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            #2;
            check("zero_after_done", 32'(done), 0);
            check("zero_after_busy", 32'(busy), 0);
            check("zero_after_en", 32'(ram_enable), 0);
            check("zero_after_valid", 32'(out_valid), 0);
        end
        $display("[TB] transfer zero_length done observed");
        tick();

        xfer("midreset", 20, 16, 4, 4);
        xfer("post_reset", 300, 5, 0, 0);
        xfer("busy_start", 40, 12, 3, 5);
        xfer("len1_top", 1023, 1, 0, 0);

        for (int i = 0; i < DEPTH; i++) mem[i] = W'($urandom);
        for (int t = 0; t < 12; t++) begin
            xfer("rand", $urandom_range(0, DEPTH - 1), $urandom_range(1, 40), 2, $urandom_range(20, 100));
        end
        xfer("full", $urandom_range(0, DEPTH - 1), DEPTH, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
